// File: rtl/sum_bcd_converter.sv
// Sequential double-dabble converter: turns an adder's carry/sum word into packed BCD
// digits over WIDTH clock cycles, holding the last result steady for a display.
module sum_bcd_converter #(
  parameter int WIDTH  = 5,
  parameter int DIGITS = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic longint pow10(input int n);
    longint p;
    p = 64'sd1;
    for (int i = 0; i < n; i++) p = p * 64'sd10;
    return p;
  endfunction

  localparam longint MAX_IN    = (64'sd1 <<< WIDTH) - 64'sd1;
  localparam longint BCD_LIMIT = pow10(DIGITS);

  generate
    if (MAX_IN >= BCD_LIMIT) begin : g_bad_params
      $error("sum_bcd_converter: DIGITS too small for WIDTH");
    end
  endgenerate

  // Double-dabble correction: any digit >= 5 gets +3 so the next shift carries into the next digit.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      else                     r[4*i +: 4] = v[4*i +: 4];
    end
    return r;
  endfunction

  logic [1:0]             state_r;
  logic [WIDTH-1:0]       bin_r;
  logic [BCD_W-1:0]       scratch_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [BCD_W-1:0]       bcd_r;
  logic                   out_valid_r;
  logic [BCD_W+WIDTH-1:0] shifted_s;

  always_comb begin
    shifted_s = {add3(scratch_r), bin_r} << 1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r     <= IDLE;
      bin_r       <= {WIDTH{1'b0}};
      scratch_r   <= {BCD_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      bcd_r       <= {BCD_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            bin_r     <= in_data;
            scratch_r <= {BCD_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            state_r   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_r <= shifted_s[BCD_W+WIDTH-1 -: BCD_W];
          bin_r     <= shifted_s[WIDTH-1:0];
          cnt_r     <= cnt_r + CNT_W'(1);
          // Last shift: publish straight from the shifter so latency is exactly WIDTH.
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            bcd_r       <= shifted_s[BCD_W+WIDTH-1 -: BCD_W];
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign bcd       = bcd_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Randomized self-checking bench for sum_bcd_converter against a decimal-arithmetic model.
module tb_sum_bcd_converter;
  localparam int W = 5;
  localparam int D = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [4*D-1:0] bcd;
  logic           out_valid;
  logic           out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  sum_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bcd      (bcd),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4*D-1:0] ref_bcd(input int v);
    logic [4*D-1:0] r;
    int x;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(output int cycles, input bit garble);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      tick();
      cycles++;
      if (garble && !out_valid) begin
        in_valid  = 1'($urandom);
        in_data   = W'($urandom);
        out_ready = 1'($urandom);
      end
    end
  endtask

  // One full transaction; hold = cycles the consumer stalls in DONE.
  task automatic convert(input logic [W-1:0] v, input int hold, input bit garble);
    int cycles;
    logic [4*D-1:0] exp;
    exp = ref_bcd(int'(v));
    check("idle_ready", 32'(in_ready), 32'd1);
    in_data   = v;
    in_valid  = 1'b1;
    out_ready = garble ? 1'($urandom) : 1'b0;
    tick();
    check("busy_after_accept", 32'(in_ready), 32'd0);
    in_valid = garble ? 1'($urandom) : 1'b0;
    in_data  = garble ? W'($urandom) : v;
    wait_result(cycles, garble);
    check("latency", 32'(cycles), 32'(W));
    check("bcd_value", 32'(bcd), 32'(exp));
    for (int i = 0; i < D; i++) check("digit_le9", 32'(bcd[4*i +: 4] <= 4'd9), 32'd1);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = garble ? 1'($urandom) : 1'b0;
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_bcd", 32'(bcd), 32'(exp));
      check("hold_busy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    check("consumed_valid", 32'(out_valid), 32'd0);
    check("consumed_ready", 32'(in_ready), 32'd1);
    check("bcd_retained", 32'(bcd), 32'(exp));
    out_ready = 1'b0;
  endtask

  initial begin
    int cycles;
    reset = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    reset = 1'b0;
    tick();

    convert(5'd31, 0, 1'b0);
    for (int v = 0; v < 32; v++) convert(W'(v), 0, 1'b0);
    convert(5'd23, 8, 1'b0);
    convert(5'd17, 0, 1'b1);

    // Simultaneous consume + new input: no bypass, accepted one edge later.
    in_data = 5'd12; in_valid = 1'b1; tick(); in_valid = 1'b0;
    wait_result(cycles, 1'b0);
    check("pre_bypass_bcd", 32'(bcd), 32'h12);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 5'd8;
    tick();
    check("no_bypass_ready", 32'(in_ready), 32'd1);
    check("no_bypass_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    tick();
    check("late_accept", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_result(cycles, 1'b0);
    check("late_latency", 32'(cycles), 32'(W));
    check("late_bcd", 32'(bcd), 32'h08);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Reset on the 3rd SHIFT edge aborts the conversion.
    in_data = 5'd29; in_valid = 1'b1; tick(); in_valid = 1'b0;
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    cycles = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) cycles++;
    end
    check("abort_no_valid", 32'(cycles), 32'd0);

    // Reset in DONE beats simultaneous out_ready and in_valid.
    in_data = 5'd19; in_valid = 1'b1; tick(); in_valid = 1'b0;
    wait_result(cycles, 1'b0);
    check("pre_rst_bcd", 32'(bcd), 32'h19);
    reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    check("rst_prio_valid", 32'(out_valid), 32'd0);
    check("rst_prio_bcd", 32'(bcd), 32'd0);
    check("rst_prio_ready", 32'(in_ready), 32'd1);

    for (int k = 0; k < 40; k++) convert(W'($urandom), int'($urandom_range(0, 3)), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sum_bcd_converter.md
SUM_BCD_CONVERTER -- requirements
Module: sum_bcd_converter

Interface
REQ-001 Parameter: WIDTH, default 5, is the binary input width (adder carry-out concatenated above the 4-bit sum).
REQ-002 Parameter: DIGITS, default 2, is the number of BCD output digits; the legal range is 2^WIDTH-1 < 10^DIGITS, and elaboration SHALL fail otherwise.
REQ-003 Port: CLOCK_50, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port: reset, input, 1 bit, is a synchronous, active-high reset.
REQ-005 Port: in_data, input, WIDTH bits, is the unsigned binary value to convert.
REQ-006 Port: in_valid, input, 1 bit, signals that in_data is presented.
REQ-007 Port: in_ready, output, 1 bit, signals that the block can accept in_data.
REQ-008 Port: bcd, output, 4*DIGITS bits, carries packed BCD with digit 0 (ones) in bcd[3:0].
REQ-009 Port: out_valid, output, 1 bit, signals that bcd holds a new, unconsumed result.
REQ-010 Port: out_ready, input, 1 bit, signals that the consumer takes the result.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE, all outputs registered or decoded from state only.
REQ-012 In IDLE, in_ready SHALL be 1; in SHIFT and DONE, in_ready SHALL be 0.
REQ-013 Input acceptance SHALL occur on an edge where in_valid=1 and in_ready=1; in_data SHALL be loaded into the binary shift register, the BCD scratch register SHALL be cleared, the iteration counter SHALL be set to 0, and the state SHALL become SHIFT.
REQ-014 In SHIFT, each edge SHALL first add 3 to every scratch digit >= 5, then shift the concatenation {scratch, binary} left by 1 bit, then increment the counter.
REQ-015 On the edge that completes shift number WIDTH, the final scratch value SHALL be written to bcd, out_valid SHALL be set to 1, and the state SHALL become DONE.
REQ-016 Latency SHALL be exactly WIDTH cycles from the acceptance edge to out_valid=1, which is 5 cycles at default parameters.
REQ-017 In DONE, out_valid SHALL remain 1 and bcd SHALL remain stable until an edge with out_ready=1; on that edge out_valid SHALL go to 0 and the state SHALL become IDLE.
REQ-018 A new input SHALL be accepted no sooner than the edge after the DONE-to-IDLE transition; there SHALL be no same-cycle bypass.
REQ-019 bcd SHALL hold its last result indefinitely after consumption and SHALL change only per REQ-015 or reset, so a downstream hex display shows a steady value.
REQ-020 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.
REQ-021 in_data changes during SHIFT SHALL NOT affect the result in progress.
REQ-022 Each digit of bcd SHALL always be in the range 0..9; for input 0 the result SHALL be all zeros, and for input 2^WIDTH-1 it SHALL be the exact decimal value.

Reset
REQ-023 When reset=1 on an edge, the state SHALL become IDLE, bcd SHALL be 0, out_valid SHALL be 0, the counter and scratch registers SHALL be 0, and in_ready SHALL be 1 from the following cycle.
REQ-024 Reset SHALL take priority over all other inputs, including a simultaneous in_valid or out_ready.
REQ-025 Reset asserted during SHIFT or DONE SHALL abort the conversion with no out_valid pulse, and bcd SHALL read 0.

Verification
REQ-026 Scenario: after reset, apply in_data=5'd31 with in_valid=1 for one cycle and hold out_ready=1 -> out_valid rises exactly 5 cycles after acceptance with bcd=8'h31, then falls after one cycle.
REQ-027 Scenario: sweep in_data over 0..31 in back-to-back transactions with out_ready=1 -> bcd matches decimal(in_data) each time, e.g. 10->8'h10, 19->8'h19, 0->8'h00, and each digit is <= 9.
REQ-028 Scenario: convert 5'd23 with out_ready=0 for 8 cycles -> out_valid and bcd=8'h23 stay stable and in_ready=0 throughout; raise out_ready -> IDLE on the next edge.
REQ-029 Scenario: accept 5'd17, then change in_data to 5'd4 and toggle in_valid during SHIFT -> result is 8'h17 and no second acceptance occurs before DONE is consumed.
REQ-030 Scenario: accept 5'd29 and assert reset on the 3rd SHIFT cycle -> out_valid never asserts, bcd=8'h00, and in_ready=1 on the cycle after reset deasserts.
REQ-031 Scenario: in the DONE cycle, assert out_ready and in_valid together with in_data=5'd8 -> the first result is consumed, the input is not accepted that cycle, it is accepted on the next edge, and bcd=8'h08 appears 5 cycles later.
